acorn128_ctrl: RTL and testbench

// - Phase sequencer for bit-serial ACORN-128 authenticated encryption. Sits directly upstream of state_update128.
// - Each step drives ca, cb, mbit and step_en. Walks init, AD, AD pad, encrypt, encrypt pad and finalize.
// - Streams ciphertext bits out and collects the 128-bit tag from the keystream bit ks_in (ksg128 output).

---
 rtl/acorn128_pkg.sv | 22 ++
 rtl/acorn128_if.sv | 39 +++
 rtl/acorn128_step_mux.sv | 66 ++++++
 rtl/acorn128_ctrl.sv | 147 ++++++++++++++
 tb/tb_acorn128_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/acorn128_pkg.sv
// Shared definitions for the ACORN-128 phase sequencer: FSM encoding and phase lengths.
package acorn128_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_AD      = 3'd2,
        S_AD_PAD  = 3'd3,
        S_ENC     = 3'd4,
        S_ENC_PAD = 3'd5,
        S_FIN     = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam int INIT_STEPS = 1792;
    localparam int PAD_STEPS  = 256;
    localparam int FIN_STEPS  = 768;
    localparam int TAG_W      = 128;
    localparam int STATE_W    = 293;
    localparam int STEP_W     = 11;

endpackage

// File: rtl/acorn128_if.sv
// Bus between the ACORN-128 sequencer and its host / state-update datapath.
interface acorn128_if #(
    parameter int LEN_W = 16
) ();
    logic             start;
    logic [127:0]     key;
    logic [127:0]     iv;
    logic [LEN_W-1:0] ad_len;
    logic [LEN_W-1:0] msg_len;
    logic             ad_valid;
    logic             ad_bit;
    logic             ad_ready;
    logic             pt_valid;
    logic             pt_bit;
    logic             pt_ready;
    logic             ks_in;
    logic             step_en;
    logic             ca;
    logic             cb;
    logic             mbit;
    logic             ct_valid;
    logic             ct_bit;
    logic [127:0]     tag;
    logic             tag_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, key, iv, ad_len, msg_len, ad_valid, ad_bit, pt_valid, pt_bit, ks_in,
        input  ad_ready, pt_ready, step_en, ca, cb, mbit, ct_valid, ct_bit, tag, tag_valid,
               busy, done
    );

    modport slave (
        input  start, key, iv, ad_len, msg_len, ad_valid, ad_bit, pt_valid, pt_bit, ks_in,
        output ad_ready, pt_ready, step_en, ca, cb, mbit, ct_valid, ct_bit, tag, tag_valid,
               busy, done
    );
endinterface

// File: rtl/acorn128_step_mux.sv
// Combinational selection of the ca/cb/mbit control bits for the current phase and step.
module acorn128_step_mux
    import acorn128_pkg::*;
(
    input  state_t             i_phase,
    input  logic [STEP_W-1:0]  i_n,
    input  logic [TAG_W-1:0]   i_key,
    input  logic [TAG_W-1:0]   i_iv,
    input  logic               i_ad_bit,
    input  logic               i_pt_bit,
    output logic               o_ca,
    output logic               o_cb,
    output logic               o_mbit
);

    logic [6:0] w_lo;
    assign w_lo = i_n[6:0];

    always_comb begin
        o_ca   = 1'b0;
        o_cb   = 1'b0;
        o_mbit = 1'b0;
        case (i_phase)
            S_INIT: begin
                o_ca = 1'b1;
                o_cb = 1'b1;
                // key, then iv, then a single inverted key[0], then key repeated
                if (i_n < 11'd128)       o_mbit = i_key[w_lo];
                else if (i_n < 11'd256)  o_mbit = i_iv[w_lo];
                else if (i_n == 11'd256) o_mbit = ~i_key[0];
                else                     o_mbit = i_key[w_lo];
            end
            S_AD: begin
                o_ca   = 1'b1;
                o_cb   = 1'b1;
                o_mbit = i_ad_bit;
            end
            S_AD_PAD: begin
                o_ca   = (i_n < 11'd128);
                o_cb   = 1'b1;
                o_mbit = (i_n == '0);
            end
            S_ENC: begin
                o_ca   = 1'b1;
                o_cb   = 1'b0;
                o_mbit = i_pt_bit;
            end
            S_ENC_PAD: begin
                o_ca   = (i_n < 11'd128);
                o_cb   = 1'b0;
                o_mbit = (i_n == '0);
            end
            S_FIN: begin
                o_ca   = 1'b1;
                o_cb   = 1'b1;
                o_mbit = 1'b0;
            end
            default: begin
                o_ca   = 1'b0;
                o_cb   = 1'b0;
                o_mbit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acorn128_ctrl.sv
// ACORN-128 phase sequencer: walks init/AD/pad/encrypt/pad/finalize, emits ciphertext and tag.
module acorn128_ctrl
    import acorn128_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    acorn128_if.slave    bus
);

    localparam logic [STEP_W-1:0] INIT_LAST = STEP_W'(INIT_STEPS - 1);
    localparam logic [STEP_W-1:0] PAD_LAST  = STEP_W'(PAD_STEPS - 1);
    localparam logic [STEP_W-1:0] FIN_LAST  = STEP_W'(FIN_STEPS - 1);
    localparam logic [STEP_W-1:0] FIN_TAG0  = STEP_W'(FIN_STEPS - TAG_W);
    localparam logic [6:0]        TAG_OFS   = 7'(FIN_STEPS - TAG_W);

    state_t             r_state;
    state_t             w_next;
    logic [STEP_W-1:0]  r_step;
    logic [LEN_W-1:0]   r_bits;
    logic [LEN_W-1:0]   r_ad_len;
    logic [LEN_W-1:0]   r_msg_len;
    logic [TAG_W-1:0]   r_key;
    logic [TAG_W-1:0]   r_iv;
    logic [TAG_W-1:0]   r_tag;
    logic               r_ct_valid;
    logic               r_ct_bit;
    logic               r_tag_valid;

    logic               w_step_en;
    logic               w_idle;
    logic               w_start;
    logic               w_enc_step;
    logic               w_fin_last;
    logic [6:0]         w_tag_idx;
    logic               w_ca;
    logic               w_cb;
    logic               w_mbit;

    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start    = bus.start && w_idle;
    assign w_enc_step = (r_state == S_ENC) && bus.pt_valid;
    assign w_fin_last = (r_state == S_FIN) && (r_step == FIN_LAST);
    // FIN_TAG0 is a multiple of 128 in practice, but the offset keeps this general
    assign w_tag_idx  = r_step[6:0] - TAG_OFS;

    always_comb begin
        w_next    = r_state;
        w_step_en = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) w_next = S_INIT;
            end
            S_INIT: begin
                w_step_en = 1'b1;
                if (r_step == INIT_LAST) w_next = (r_ad_len == '0) ? S_AD_PAD : S_AD;
            end
            S_AD: begin
                w_step_en = bus.ad_valid;
                if (bus.ad_valid && (r_bits == r_ad_len - LEN_W'(1))) w_next = S_AD_PAD;
            end
            S_AD_PAD: begin
                w_step_en = 1'b1;
                if (r_step == PAD_LAST) w_next = (r_msg_len == '0) ? S_ENC_PAD : S_ENC;
            end
            S_ENC: begin
                w_step_en = bus.pt_valid;
                if (bus.pt_valid && (r_bits == r_msg_len - LEN_W'(1))) w_next = S_ENC_PAD;
            end
            S_ENC_PAD: begin
                w_step_en = 1'b1;
                if (r_step == PAD_LAST) w_next = S_FIN;
            end
            S_FIN: begin
                w_step_en = 1'b1;
                if (r_step == FIN_LAST) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_bits      <= '0;
            r_tag       <= '0;
            r_ct_bit    <= 1'b0;
            r_ct_valid  <= 1'b0;
            r_tag_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ct_valid  <= w_enc_step;
            r_tag_valid <= w_fin_last;
            if (w_enc_step) r_ct_bit <= bus.pt_bit ^ bus.ks_in;
            // counters restart on every phase entry, including the start itself
            if (w_start || (w_next != r_state)) begin
                r_step <= '0;
                r_bits <= '0;
            end else if (w_step_en) begin
                r_step <= r_step + STEP_W'(1);
                r_bits <= r_bits + LEN_W'(1);
            end
            if (w_start) begin
                r_tag <= '0;
            end else if ((r_state == S_FIN) && (r_step >= FIN_TAG0)) begin
                r_tag[w_tag_idx] <= bus.ks_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_key     <= bus.key;
            r_iv      <= bus.iv;
            r_ad_len  <= bus.ad_len;
            r_msg_len <= bus.msg_len;
        end
    end

    acorn128_step_mux u_mux (
        .i_phase  (r_state),
        .i_n      (r_step),
        .i_key    (r_key),
        .i_iv     (r_iv),
        .i_ad_bit (bus.ad_bit),
        .i_pt_bit (bus.pt_bit),
        .o_ca     (w_ca),
        .o_cb     (w_cb),
        .o_mbit   (w_mbit)
    );

    assign bus.step_en   = w_step_en;
    assign bus.ca        = w_ca;
    assign bus.cb        = w_cb;
    assign bus.mbit      = w_mbit;
    assign bus.ad_ready  = (r_state == S_AD);
    assign bus.pt_ready  = (r_state == S_ENC);
    assign bus.ct_valid  = r_ct_valid;
    assign bus.ct_bit    = r_ct_bit;
    assign bus.tag       = r_tag;
    assign bus.tag_valid = r_tag_valid;
    assign bus.busy      = !w_idle;
    assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Scoreboard bench for the ACORN-128 phase sequencer.
module tb_acorn128_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acorn128_if #(.LEN_W(16)) bus ();

    acorn128_ctrl #(.LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    int           tv_count = 0;
    logic         ctq[$];
    logic [127:0] tagq[$];
    logic [15:0]  ct_seq = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic int ref_phase(input int g, input int adl, input int ml);
        if (g < 1792) return 0;
        g -= 1792;
        if (g < adl) return 1;
        g -= adl;
        if (g < 256) return 2;
        g -= 256;
        if (g < ml) return 3;
        g -= ml;
        if (g < 256) return 4;
        g -= 256;
        if (g < 768) return 5;
        return 6;
    endfunction

    // {ca, cb, mbit} expected for global step g
    function automatic logic [2:0] ref_ctl(input int g, input int adl, input int ml,
                                           input logic [127:0] k, input logic [127:0] v,
                                           input logic ab, input logic pb);
        if (g < 1792) begin
            if (g < 128)  return {2'b11, k[g]};
            if (g < 256)  return {2'b11, v[g-128]};
            if (g == 256) return {2'b11, ~k[0]};
            return {2'b11, k[g%128]};
        end
        g -= 1792;
        if (g < adl) return {2'b11, ab};
        g -= adl;
        if (g < 256) return {(g < 128), 1'b1, (g == 0)};
        g -= 256;
        if (g < ml) return {2'b10, pb};
        g -= ml;
        if (g < 256) return {(g < 128), 1'b0, (g == 0)};
        return 3'b110;
    endfunction

    always @(negedge clk) begin
        if (bus.ct_valid === 1'b1) begin
            ct_seq = {ct_seq[14:0], bus.ct_bit};
            if (ctq.size() == 0) chk("ct_spurious", 128'(1), 128'(0));
            else                 chk("ct_bit", 128'(bus.ct_bit), 128'(ctq.pop_front()));
        end
        if (bus.tag_valid === 1'b1) begin
            tv_count++;
            if (tagq.size() == 0) chk("tag_spurious", 128'(1), 128'(0));
            else                  chk("tag", bus.tag, tagq.pop_front());
        end
    end

    task automatic run(input logic [127:0] k, input logic [127:0] v, input int adl, input int ml,
                       input int ks_mode, input logic [15:0] pt_pat, input logic [15:0] ks_pat,
                       input bit stall, input bit spot, input bit busy_start, input int exp_cyc);
        int g, cyc, mism, dut_steps, total, budget, ph, idx, f, tv0;
        logic exp_en;
        logic [2:0] r;
        logic [127:0] exp_tag;
        total = 3072 + adl + ml;
        budget = total + 4 * (adl + ml) + 100;
        g = 0; cyc = 0; mism = 0; dut_steps = 0; exp_tag = '0;
        ctq.delete(); tagq.delete(); ct_seq = '0;
        @(negedge clk);
        bus.key = k; bus.iv = v; bus.ad_len = 16'(adl); bus.msg_len = 16'(ml); bus.start = 1'b1;
        #1 chk("pre_start_en", 128'(bus.step_en), 128'(0));
        @(negedge clk);
        bus.start = 1'b0; bus.key = ~k; bus.iv = ~v; tv0 = tv_count;
        while (g < total && cyc < budget) begin
            ph  = ref_phase(g, adl, ml);
            idx = g - (1792 + adl + 256);
            f   = g - (total - 768);
            bus.ad_valid = stall ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.pt_valid = stall ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.ad_bit   = 1'($urandom_range(0, 1));
            bus.pt_bit   = (ph == 3 && idx < 16) ? pt_pat[idx] : 1'($urandom_range(0, 1));
            if (ph == 5 && ks_mode == 1)      bus.ks_in = 1'b1;
            else if (ph == 5 && ks_mode == 2) bus.ks_in = (g == total - 1);
            else if (ph == 3 && idx < 16)     bus.ks_in = ks_pat[idx];
            else                              bus.ks_in = 1'($urandom_range(0, 1));
            bus.start = busy_start && (g == 100);
            #1;
            exp_en = (ph == 1) ? bus.ad_valid : (ph == 3) ? bus.pt_valid : 1'b1;
            if (bus.step_en !== exp_en || bus.ad_ready !== (ph == 1) || bus.pt_ready !== (ph == 3)
                || bus.busy !== 1'b1 || bus.done !== 1'b0) mism++;
            if (exp_en) begin
                r = ref_ctl(g, adl, ml, k, v, bus.ad_bit, bus.pt_bit);
                if ({bus.ca, bus.cb, bus.mbit} !== r) mism++;
                if (spot && ph == 0 && (g == 0 || g == 256 || g == 257 || g == 384))
                    chk($sformatf("init_mbit_%0d", g), 128'(bus.mbit), 128'(g == 0 || g == 384));
                if (ph == 3) ctq.push_back(bus.pt_bit ^ bus.ks_in);
                if (ph == 5 && f >= 640) exp_tag[f-640] = bus.ks_in;
                if (g == total - 1) tagq.push_back(exp_tag);
                g++;
            end
            if (bus.step_en === 1'b1) dut_steps++;
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("run_done", 128'(g), 128'(total));
        chk("steps", 128'(dut_steps), 128'(total));
        if (exp_cyc >= 0) chk("cycles", 128'(cyc), 128'(exp_cyc));
        chk("ctl_mism", 128'(mism), 128'(0));
        #1;
        chk("tag_valid", 128'(bus.tag_valid), 128'(1));
        chk("done", 128'(bus.done), 128'(1));
        chk("busy_end", 128'(bus.busy), 128'(0));
        chk("en_end", 128'(bus.step_en), 128'(0));
        @(negedge clk);
        #1;
        chk("tag_valid_off", 128'(bus.tag_valid), 128'(0));
        chk("tag_hold", bus.tag, exp_tag);
        chk("tv_pulses", 128'(tv_count - tv0), 128'(1));
        chk("ct_drained", 128'(ctq.size()), 128'(0));
    endtask

    task automatic abort_test();
        int tv0;
        tv0 = tv_count;
        @(negedge clk);
        bus.ad_len = 16'd8; bus.msg_len = 16'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.ad_valid = 1'b1;
        repeat (1792 + 3) @(negedge clk);
        #1 chk("abort_in_ad", 128'(bus.ad_ready), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_ready", 128'(bus.ad_ready), 128'(0));
        chk("abort_en", 128'(bus.step_en), 128'(0));
        chk("abort_done", 128'(bus.done), 128'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_tv", 128'(tv_count - tv0), 128'(0));
        chk("abort_idle", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.key = '0; bus.iv = '0; bus.ad_len = '0; bus.msg_len = '0;
        bus.ad_valid = 1'b1; bus.ad_bit = 1'b0; bus.pt_valid = 1'b1; bus.pt_bit = 1'b0;
        bus.ks_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_tag_valid", 128'(bus.tag_valid), 128'(0));
        chk("rst_ct_valid", 128'(bus.ct_valid), 128'(0));
        chk("rst_tag", bus.tag, 128'(0));
        chk("rst_ad_ready", 128'(bus.ad_ready), 128'(0));
        chk("rst_pt_ready", 128'(bus.pt_ready), 128'(0));
        chk("rst_step_en", 128'(bus.step_en), 128'(0));
        rst = 1'b0;

        run(128'h1, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 16'h0, 16'h0,
            1'b0, 1'b1, 1'b0, 3072);
        chk("tag_all_ones", bus.tag, {128{1'b1}});

        run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            8, 4, 2, 16'h000D, 16'h0006, 1'b1, 1'b0, 1'b0, -1);
        chk("ct_seq", 128'(ct_seq[3:0]), 128'(4'b1101));
        chk("tag_msb_only", bus.tag, {1'b1, 127'b0});

        run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            37, 53, 0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, -1);

        abort_test();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
